// File: rtl/sort_pipe.sv
// rtl/sort_pipe.sv - pipelined odd-even transposition sorter with per-vector direction
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_data carries N elements of W bits (element i at [i*W +: W])
//   in_dir_en/in_desc     per-vector direction select (in_desc used when in_dir_en = 1, else DESC_DEFAULT)
//   out_valid/out_ready   output handshake; out_data is the sorted vector, out_desc the direction applied
//   busy                  any stage holds a valid vector
module sort_pipe #(
    parameter int W            = 9,
    parameter int N            = 9,
    parameter int DESC_DEFAULT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic             in_dir_en,
    input  logic             in_desc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_data,
    output logic             out_desc,
    output logic             busy
);

    // One compare-exchange layer: pairs (j, j+1) with j of the given parity.
    // Equal elements are never swapped, which keeps the sort stable.
    function automatic logic [N*W-1:0] cx_layer(input logic [N*W-1:0] v,
                                                input logic odd,
                                                input logic desc);
        logic [N*W-1:0] r;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        r = v;
        for (int j = 0; j < N - 1; j++) begin
            if ((j % 2) == int'(odd)) begin
                a = v[j*W +: W];
                b = v[(j+1)*W +: W];
                if (desc ? (a < b) : (a > b)) begin
                    r[j*W +: W]     = b;
                    r[(j+1)*W +: W] = a;
                end
            end
        end
        return r;
    endfunction

    logic [N*W-1:0] data_q    [N];
    logic [N-1:0]   valid_q;
    logic [N-1:0]   desc_q;

    logic [N*W-1:0] stage_in  [N];
    logic [N*W-1:0] stage_out [N];
    logic [N-1:0]   stage_dir;

    logic           in_dir;
    logic           stall;

    assign in_dir = in_dir_en ? in_desc : (DESC_DEFAULT != 0);

    // The whole pipeline freezes while the last stage waits on the consumer,
    // so in_ready only depends on out_ready and the last valid bit.
    assign stall    = valid_q[N-1] & ~out_ready;
    assign in_ready = ~stall;

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign stage_in[k]  = in_data;
                assign stage_dir[k] = in_dir;
            end else begin : g_rest
                assign stage_in[k]  = data_q[k-1];
                assign stage_dir[k] = desc_q[k-1];
            end
            assign stage_out[k] = cx_layer(stage_in[k], 1'((k % 2) == 1), stage_dir[k]);
        end
    endgenerate

    // Bubbles advance like real entries; their data is don't-care but still
    // deterministic because it is just the layer applied to whatever came in.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            desc_q  <= '0;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= '0;
            end
        end else if (!stall) begin
            valid_q <= {valid_q[N-2:0], in_valid};
            desc_q  <= stage_dir;
            for (int i = 0; i < N; i++) begin
                data_q[i] <= stage_out[i];
            end
        end
    end

    assign out_valid = valid_q[N-1];
    assign out_data  = data_q[N-1];
    assign out_desc  = desc_q[N-1];
    assign busy      = |valid_q;

endmodule

// File: tb/tb_sort_pipe.sv
// tb/tb_sort_pipe.sv - self-checking bench for sort_pipe against a queue-based reference model
module tb_sort_pipe;

    localparam int W  = 9;
    localparam int N  = 9;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] in_data;
    logic          in_dir_en;
    logic          in_desc;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] out_data;
    logic          out_desc;
    logic          busy;

    int checks    = 0;
    int failures  = 0;
    int delivered = 0;

    // Reference model: vectors in flight in acceptance order, with the number
    // of pipeline advances each one has seen since acceptance.
    logic [NW-1:0] exp_d   [$];
    logic          exp_s   [$];
    int            exp_age [$];

    sort_pipe #(.W(W), .N(N), .DESC_DEFAULT(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir_en (in_dir_en),
        .in_desc   (in_desc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_desc  (out_desc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NW-1:0] ref_sort(input logic [NW-1:0] v, input logic desc);
        int a [N];
        int t;
        logic [NW-1:0] r;
        for (int i = 0; i < N; i++) a[i] = int'(v[i*W +: W]);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (desc ? (a[j] < a[j+1]) : (a[j] > a[j+1])) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i][W-1:0];
        return r;
    endfunction

    function automatic logic [NW-1:0] pack(input int a [N]);
        logic [NW-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = a[i][W-1:0];
        return r;
    endfunction

    function automatic logic [NW-1:0] rand_vec(input int maxv);
        logic [NW-1:0] r;
        int x;
        for (int i = 0; i < N; i++) begin
            x = int'($urandom_range(0, maxv));
            r[i*W +: W] = x[W-1:0];
        end
        return r;
    endfunction

    function automatic logic model_ov();
        return (exp_age.size() > 0) && (exp_age[0] == N - 1);
    endfunction

    task automatic chk(input string tag, input logic [NW-1:0] got, input logic [NW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check outputs against the model,
    // advance the model to what the coming rising edge will do.
    task automatic step(input logic iv, input logic [NW-1:0] id, input logic den,
                        input logic ds, input logic ordy, input logic irst,
                        output logic acc);
        logic eov;
        logic stall;
        logic dd;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        in_dir_en = den;
        in_desc   = ds;
        out_ready = ordy;
        rst       = irst;
        #1;
        eov   = model_ov();
        stall = eov && !ordy;
        chk("out_valid", NW'(out_valid), NW'(eov));
        chk("busy", NW'(busy), NW'(exp_d.size() > 0));
        chk("in_ready", NW'(in_ready), NW'(!stall));
        if (eov) begin
            chk("out_data", out_data, exp_d[0]);
            chk("out_desc", NW'(out_desc), NW'(exp_s[0]));
        end
        acc = !irst && iv && !stall;
        dd  = den ? ds : 1'b0;
        if (irst) begin
            exp_d.delete();
            exp_s.delete();
            exp_age.delete();
        end else if (!stall) begin
            if (eov) begin
                void'(exp_d.pop_front());
                void'(exp_s.pop_front());
                void'(exp_age.pop_front());
                delivered++;
            end
            foreach (exp_age[i]) exp_age[i] = exp_age[i] + 1;
            if (iv) begin
                exp_d.push_back(ref_sort(id, dd));
                exp_s.push_back(dd);
                exp_age.push_back(0);
            end
        end
        @(posedge clk);
    endtask

    task automatic bubble(input logic ordy);
        logic acc;
        step(1'b0, rand_vec(511), 1'b0, 1'b0, ordy, 1'b0, acc);
    endtask

    task automatic push(input logic [NW-1:0] d, input logic den, input logic ds);
        logic acc;
        step(1'b1, d, den, ds, 1'b1, 1'b0, acc);
        chk("push_accepted", NW'(acc), NW'(1'b1));
    endtask

    // Directed check of the presented output, taken just after a rising edge.
    task automatic expect_out(input string tag, input logic [NW-1:0] d, input logic ds);
        #2;
        chk({tag, "_valid"}, NW'(out_valid), NW'(1'b1));
        chk({tag, "_data"}, out_data, d);
        chk({tag, "_desc"}, NW'(out_desc), NW'(ds));
    endtask

    initial begin
        int            tv [N];
        logic [NW-1:0] va;
        logic [NW-1:0] vb;
        logic [NW-1:0] sd  [12];
        logic          sen [12];
        logic          sds [12];
        logic          acc;
        logic          ordy;
        int            idx;
        int            base;
        int            guard;
        int            stall_left;
        bit            stalled_once;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_dir_en = 1'b0;
        in_desc   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", NW'(out_valid), '0);
        chk("rst_busy", NW'(busy), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_desc", NW'(out_desc), '0);
        chk("rst_in_ready", NW'(in_ready), NW'(1'b1));

        // Reversed vector, default (ascending) direction, latency N.
        tv = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        va = pack(tv);
        push(va, 1'b0, 1'b1);
        repeat (N - 1) bubble(1'b1);
        tv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        expect_out("rev_asc", pack(tv), 1'b0);
        bubble(1'b1);

        // Back-to-back vectors with different directions.
        tv = '{19, 18, 17, 16, 11, 12, 13, 14, 15};
        va = pack(tv);
        tv = '{29, 28, 27, 26, 21, 22, 23, 24, 25};
        vb = pack(tv);
        push(va, 1'b1, 1'b1);
        push(vb, 1'b0, 1'b1);
        repeat (N - 2) bubble(1'b1);
        tv = '{19, 18, 17, 16, 15, 14, 13, 12, 11};
        expect_out("b2b_desc", pack(tv), 1'b1);
        bubble(1'b1);
        tv = '{21, 22, 23, 24, 25, 26, 27, 28, 29};
        expect_out("b2b_asc", pack(tv), 1'b0);
        bubble(1'b1);

        // Duplicates and extremes.
        tv = '{511, 0, 5, 5, 511, 0, 3, 3, 1};
        push(pack(tv), 1'b0, 1'b0);
        repeat (N - 1) bubble(1'b1);
        tv = '{0, 0, 1, 3, 3, 5, 5, 511, 511};
        expect_out("dup_ext", pack(tv), 1'b0);
        bubble(1'b1);

        // Stream of 12 with a 3-cycle consumer stall once output appears.
        for (int i = 0; i < 12; i++) begin
            sd[i]  = rand_vec((i % 3 == 0) ? 7 : 511);
            sen[i] = 1'($urandom_range(0, 1));
            sds[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; base = delivered; guard = 0; stall_left = 0; stalled_once = 0;
        while ((delivered - base) < 12 && guard < 200) begin
            ordy = 1'b1;
            if (!stalled_once && model_ov()) begin
                stall_left   = 3;
                stalled_once = 1;
            end
            if (stall_left > 0) begin
                ordy = 1'b0;
                stall_left--;
            end
            if (idx < 12) step(1'b1, sd[idx], sen[idx], sds[idx], ordy, 1'b0, acc);
            else          step(1'b0, '0, 1'b0, 1'b0, ordy, 1'b0, acc);
            if (acc) idx++;
            guard++;
        end
        chk("stream_delivered", NW'(delivered - base), NW'(12));
        chk("stream_stalled", NW'(stalled_once), NW'(1));

        // Random traffic with random backpressure, then drain.
        for (int c = 0; c < 80; c++) begin
            step(1'($urandom_range(0, 1)), rand_vec(($urandom_range(0, 1) != 0) ? 511 : 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'b0, acc);
        end
        guard = 0;
        while (exp_d.size() > 0 && guard < 4 * N) begin
            bubble(1'b1);
            guard++;
        end
        chk("drain_empty", NW'(exp_d.size()), '0);

        // Reset with vectors in flight.
        for (int i = 0; i < 4; i++) push(rand_vec(511), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        #2;
        chk("midrst_out_valid", NW'(out_valid), '0);
        chk("midrst_busy", NW'(busy), '0);
        repeat (N + 2) bubble(1'b1);
        tv = '{100, 3, 77, 3, 0, 511, 42, 8, 200};
        push(pack(tv), 1'b1, 1'b1);
        repeat (N - 1) bubble(1'b1);
        tv = '{511, 200, 100, 77, 42, 8, 3, 3, 0};
        expect_out("post_rst", pack(tv), 1'b1);
        bubble(1'b1);
        bubble(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sort_pipe.md
SORT_PIPE -- requirements
Module: sort_pipe

Interface
REQ-001 Parameter W, default 9: element width in bits, unsigned, W >= 1.
REQ-002 Parameter N, default 9: elements per vector, N >= 2.
REQ-003 Parameter DESC_DEFAULT, default 0: sort direction used when in_dir_en = 0 (0 ascending, 1 descending).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input vector present.
REQ-007 in_ready  output  1  block can accept input this cycle.
REQ-008 in_data  input  N*W  unsorted vector; element i at bits [i*W +: W].
REQ-009 in_dir_en  input  1  1: use in_desc for this vector; 0: use DESC_DEFAULT.
REQ-010 in_desc  input  1  per-vector direction (1 descending), sampled with in_data.
REQ-011 out_valid  output  1  sorted vector present.
REQ-012 out_ready  input  1  consumer accepts output this cycle.
REQ-013 out_data  output  N*W  sorted vector, same packing as in_data.
REQ-014 out_desc  output  1  direction actually applied to out_data.
REQ-015 busy  output  1  1 when any pipeline stage holds a valid vector.

Function
REQ-016 Sorting is an N-stage odd-even transposition network; stage k (0..N-1) compare-exchanges pairs (j, j+1) with j even for even k and j odd for odd k.
REQ-017 Each stage is followed by one register holding N*W data bits, a direction bit and a valid bit.
REQ-018 Compare-exchange: ascending swaps only when element j > element j+1 (unsigned); descending swaps only when element j < element j+1; equal elements never swap (stable).
REQ-019 Direction is captured at acceptance and travels with its vector; vectors with different directions coexist in the pipeline.
REQ-020 Handshake: input accepted on a rising edge when in_valid = 1 and in_ready = 1; output consumed when out_valid = 1 and out_ready = 1.
REQ-021 Stall = out_valid & ~out_ready; in_ready = ~stall; during stall every stage register holds its value.
REQ-022 Without stall, all stages advance each edge; bubbles (in_valid = 0) advance as invalid entries.
REQ-023 Latency: a vector accepted on edge E appears with out_valid = 1 immediately after edge E+N-1; throughput one vector per cycle.
REQ-024 Simultaneous accept and consume in the same cycle is legal and loses no vector.
REQ-025 out_data, out_desc stable while out_valid = 1 and out_ready = 0.
REQ-026 out_data is the last-stage register; don't-care but deterministic when out_valid = 0.
REQ-027 busy = OR of all stage valid bits.
REQ-028 No combinational path from in_valid or in_data to any output; in_ready depends only on out_ready and registered state.

Reset
REQ-029 When rst = 1 on an edge: all stage valid bits, out_valid and busy become 0; data and direction registers become 0.
REQ-030 Reset mid-operation discards every in-flight vector; no partial vector is ever presented afterwards.
REQ-031 During rst = 1, in_ready = 1 per REQ-021 but no input is accepted; first acceptance is the first edge with rst = 0.

Verification (W=9, N=9, DESC_DEFAULT=0)
REQ-032 in_data {9,8,7,6,5,4,3,2,1} (element 0 first), in_dir_en=0, out_ready=1 -> after 9 edges out_data {1,2,3,4,5,6,7,8,9}, out_desc=0.
REQ-033 Back-to-back {19,18,17,16,11,12,13,14,15} with in_dir_en=1,in_desc=1 then {29,28,27,26,21,22,23,24,25} with in_dir_en=0 -> consecutive outputs {19,18,17,16,15,14,13,12,11} (out_desc=1) then {21..29} ascending.
REQ-034 Duplicates and extremes {511,0,5,5,511,0,3,3,1} ascending -> {0,0,1,3,3,5,5,511,511}.
REQ-035 Stream of 12 vectors with out_ready low 3 cycles once output valid -> in_ready low those cycles, out_data unchanged, all 12 vectors delivered in order, none duplicated.
REQ-036 Assert rst after 4 vectors accepted, before any output -> out_valid and busy 0 next cycle, no stale vector emitted; new vector after reset sorts correctly with latency 9.
